// File: rtl/excess3_updown_counter.sv
// Debounced up/down digit counter (0..7) presenting an excess-3 (mod 8) code.
// Optional auto-increment tick enabled by defining EXCESS3_AUTO_COUNT_EN.
module excess3_updown_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
`ifdef EXCESS3_AUTO_COUNT_EN
  input  logic       auto_en,
`endif
  output logic [2:0] num,
  output logic       carry,
  output logic       borrow
);

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  // Index 0 = up button, index 1 = down button.
  logic [1:0]        btn_raw;
  logic [1:0]        s1_q, s2_q;
  logic [1:0]        db_q, db_d;
  logic [1:0]        db_prev_q;
  logic [1:0][23:0]  cnt_q, cnt_d;
  logic [1:0]        press;

  assign btn_raw = {btn_down, btn_up};

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press = db_q & ~db_prev_q;

  logic auto_up;

`ifdef EXCESS3_AUTO_COUNT_EN
  localparam logic [25:0] TICK_LAST = 26'(TICK_CYCLES - 1);

  logic [25:0] tick_q, tick_d;

  always_comb begin
    tick_d = '0;
    if (auto_en) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 26'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_d;
  end

  assign auto_up = (tick_q == TICK_LAST);
`else
  assign auto_up = 1'b0;
`endif

  logic       up_ev, dn_ev;
  logic [2:0] digit_q, digit_d;
  logic [2:0] num_q, num_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;

  assign up_ev = press[0] | auto_up;
  assign dn_ev = press[1];

  // Simultaneous up and down events cancel out.
  always_comb begin
    digit_d  = digit_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (up_ev && !dn_ev) begin
      digit_d = digit_q + 3'd1;
      carry_d = (digit_q == 3'd7);
    end else if (dn_ev && !up_ev) begin
      digit_d  = digit_q - 3'd1;
      borrow_d = (digit_q == 3'd0);
    end
    num_d = digit_d + 3'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q  <= 3'd0;
      num_q    <= 3'b011;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      num_q    <= num_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign num    = num_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule
